// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the RV32I multicycle control unit.
package multicycle_control_unit_pkg;

  // ALU operation select.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  // Controller states, kept as plain constants for legacy tools.
  typedef logic [2:0] ctrl_state_t;
  localparam ctrl_state_t ST_FETCH  = 3'd0;
  localparam ctrl_state_t ST_DECODE = 3'd1;
  localparam ctrl_state_t ST_EXEC   = 3'd2;
  localparam ctrl_state_t ST_MEM    = 3'd3;
  localparam ctrl_state_t ST_WB     = 3'd4;
  localparam ctrl_state_t ST_TRAP   = 3'd5;

  // RV32I base opcodes handled here.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Immediate formats.
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  // Writeback source.
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // PC source.
  localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SRC_TARGET = 2'd1;
  localparam logic [1:0] PC_SRC_JALR   = 2'd2;

  // ALU operand selects.
  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;
  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  // Memory access size.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Coarse instruction class, drives the FSM path through EXEC/MEM/WB.
  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_JAL    = 3'd4,
    CLS_JALR   = 3'd5,
    CLS_LUI    = 3'd6,
    CLS_AUIPC  = 3'd7
  } instr_class_t;

  // Decoded fields latched once per instruction.
  typedef struct packed {
    instr_class_t cls;
    alu_op_t      alu_op;
    logic [1:0]   alu_src_b;
    logic [2:0]   imm_sel;
    logic [2:0]   funct3;
    logic [1:0]   read_size;
    logic         read_signed;
    logic [3:0]   store_we;
  } dec_t;

  // funct3 to ALU op; alt selects SUB/SRA (funct7 bit 5).
  function automatic alu_op_t funct_to_alu_op(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_instr_field_decoder.sv
// Combinational RV32I opcode/funct decode: class, ALU op, immediate format,
// legality and load/store sizing.
module multicycle_control_unit_instr_field_decoder
  import multicycle_control_unit_pkg::*;
#(
  parameter bit ENABLE_JUMPS = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output dec_t       dec,
  output logic       legal
);

  // Decode one instruction word into control fields.
  always_comb begin
    dec         = '0;
    dec.cls     = CLS_ALU;
    dec.alu_op  = ALU_ADD;
    dec.funct3  = funct3;
    legal       = 1'b0;
    case (opcode)
      OP_R: begin
        dec.alu_src_b = SRC_B_RS2;
        dec.alu_op    = funct_to_alu_op(funct3, funct7[5]);
        legal = (funct7 == 7'b0000000) ||
                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OP_I: begin
        dec.alu_src_b = SRC_B_IMM;
        dec.imm_sel   = IMM_I;
        // Only the shift-right form reads funct7; ADDI never means SUB.
        dec.alu_op    = funct_to_alu_op(funct3, (funct3 == 3'b101) && funct7[5]);
        case (funct3)
          3'b001:  legal = (funct7 == 7'b0000000);
          3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          default: legal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        dec.cls         = CLS_LOAD;
        dec.alu_src_b   = SRC_B_IMM;
        dec.imm_sel     = IMM_I;
        dec.read_size   = funct3[1:0];
        dec.read_signed = ~funct3[2];
        legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
      end
      OP_STORE: begin
        dec.cls       = CLS_STORE;
        dec.alu_src_b = SRC_B_IMM;
        dec.imm_sel   = IMM_S;
        case (funct3)
          3'b000:  begin dec.store_we = 4'b0001; legal = 1'b1; end
          3'b001:  begin dec.store_we = 4'b0011; legal = 1'b1; end
          3'b010:  begin dec.store_we = 4'b1111; legal = 1'b1; end
          default: begin dec.store_we = 4'b0000; legal = 1'b0; end
        endcase
      end
      OP_BRANCH: begin
        dec.cls       = CLS_BRANCH;
        dec.alu_op    = ALU_SUB;
        dec.alu_src_b = SRC_B_RS2;
        dec.imm_sel   = IMM_B;
        legal         = (funct3[2:1] != 2'b01);
      end
      OP_LUI: begin
        dec.cls       = CLS_LUI;
        dec.alu_src_b = SRC_B_IMM;
        dec.imm_sel   = IMM_U;
        legal         = ENABLE_JUMPS;
      end
      OP_AUIPC: begin
        dec.cls       = CLS_AUIPC;
        dec.alu_src_b = SRC_B_IMM;
        dec.imm_sel   = IMM_U;
        legal         = ENABLE_JUMPS;
      end
      OP_JAL: begin
        dec.cls       = CLS_JAL;
        dec.alu_src_b = SRC_B_IMM;
        dec.imm_sel   = IMM_J;
        legal         = ENABLE_JUMPS;
      end
      OP_JALR: begin
        dec.cls       = CLS_JALR;
        dec.alu_src_b = SRC_B_IMM;
        dec.imm_sel   = IMM_I;
        legal         = ENABLE_JUMPS && (funct3 == 3'b000);
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// RV32I multicycle control FSM: fetch, decode, execute, memory, writeback,
// with memory wait states, a bounded bus timeout and sticky trap flags.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter bit          ENABLE_JUMPS = 1'b1,
  localparam int unsigned TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_zero_lt,
  output logic        mem_req,
  output logic        mem_is_fetch,
  output logic [3:0]  mem_we,
  output logic [1:0]  mem_read_size,
  output logic        mem_read_signed,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output alu_op_t     alu_op,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  imm_sel,
  output logic [2:0]  branch_type,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic        bus_error,
  output logic        instret
);

  ctrl_state_t     state_q, state_d;
  dec_t            dec, dec_q;
  logic            dec_legal;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            illegal_q, illegal_d;
  logic            bus_error_q, bus_error_d;
  logic            mem_wait, timeout_hit;
  logic            is_jump;
  logic [1:0]      src_a_sel;

  // Register specifiers are routed by the datapath, not by the controller.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  multicycle_control_unit_instr_field_decoder #(
    .ENABLE_JUMPS (ENABLE_JUMPS)
  ) u_decoder (
    .opcode (instr[6:0]),
    .funct3 (instr[14:12]),
    .funct7 (instr[31:25]),
    .dec    (dec),
    .legal  (dec_legal)
  );

  assign mem_wait    = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
  // mem_ready in the final allowed cycle still wins since mem_wait is then low.
  assign timeout_hit = mem_wait && (cnt_q >= TO_W'(MEM_TIMEOUT - 1));
  assign is_jump     = (dec_q.cls == CLS_JAL) || (dec_q.cls == CLS_JALR);

  // Operand A depends only on the instruction class.
  always_comb begin
    case (dec_q.cls)
      CLS_LUI:           src_a_sel = SRC_A_ZERO;
      CLS_AUIPC, CLS_JAL: src_a_sel = SRC_A_PC;
      default:           src_a_sel = SRC_A_RS1;
    endcase
  end

  // State, decoded fields, timeout counter and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      dec_q       <= '0;
      cnt_q       <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
      if (state_q == ST_DECODE) begin
        dec_q <= dec;
      end
    end
  end

  // Next state, flag updates and timeout counting.
  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    bus_error_d = bus_error_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else if (timeout_hit) begin
          state_d     = ST_TRAP;
          bus_error_d = 1'b1;
        end
      end
      ST_DECODE: begin
        if (dec_legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end
      end
      ST_EXEC: begin
        case (dec_q.cls)
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_BRANCH:          state_d = ST_FETCH;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_d = (dec_q.cls == CLS_STORE) ? ST_FETCH : ST_WB;
        end else if (timeout_hit) begin
          state_d     = ST_TRAP;
          bus_error_d = 1'b1;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase

    cnt_d = cnt_q;
    if ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM))) begin
      cnt_d = '0;
    end else if (mem_wait && (cnt_q != TO_W'(MEM_TIMEOUT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Moore control outputs; a few strobes are qualified by mem_ready/alu_zero_lt.
  always_comb begin
    mem_req         = 1'b0;
    mem_is_fetch    = 1'b0;
    mem_we          = 4'b0000;
    mem_read_size   = 2'd0;
    mem_read_signed = 1'b0;
    ir_write        = 1'b0;
    pc_write        = 1'b0;
    pc_src          = PC_SRC_PLUS4;
    alu_op          = ALU_ADD;
    alu_src_a       = 2'd0;
    alu_src_b       = 2'd0;
    imm_sel         = 3'd0;
    branch_type     = 3'd0;
    reg_write       = 1'b0;
    wb_sel          = WB_ALU;
    instret         = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req       = 1'b1;
        mem_is_fetch  = 1'b1;
        mem_read_size = SIZE_WORD;
        ir_write      = mem_ready;
      end
      ST_EXEC: begin
        alu_op    = dec_q.alu_op;
        alu_src_a = src_a_sel;
        alu_src_b = dec_q.alu_src_b;
        imm_sel   = dec_q.imm_sel;
        case (dec_q.cls)
          CLS_BRANCH: begin
            branch_type = dec_q.funct3;
            pc_write    = 1'b1;
            pc_src      = alu_zero_lt ? PC_SRC_TARGET : PC_SRC_PLUS4;
            instret     = 1'b1;
          end
          CLS_JAL: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_TARGET;
          end
          CLS_JALR: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_JALR;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        // Keep the address computation live while the access is pending.
        alu_op    = dec_q.alu_op;
        alu_src_a = src_a_sel;
        alu_src_b = dec_q.alu_src_b;
        imm_sel   = dec_q.imm_sel;
        if (dec_q.cls == CLS_STORE) begin
          mem_we   = dec_q.store_we;
          pc_write = mem_ready;
          instret  = mem_ready;
        end else begin
          mem_read_size   = dec_q.read_size;
          mem_read_signed = dec_q.read_signed;
        end
      end
      ST_WB: begin
        alu_op    = dec_q.alu_op;
        alu_src_a = src_a_sel;
        alu_src_b = dec_q.alu_src_b;
        imm_sel   = dec_q.imm_sel;
        reg_write = 1'b1;
        instret   = 1'b1;
        pc_write  = !is_jump;
        case (dec_q.cls)
          CLS_LOAD:          wb_sel = WB_MEM;
          CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
          default:           wb_sel = WB_ALU;
        endcase
      end
      default: ;
    endcase
    // No request or write may escape while reset is held.
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 4'b0000;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      instret   = 1'b0;
    end
  end

  assign illegal   = illegal_q;
  assign bus_error = bus_error_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for the multicycle control unit; expected values hand-derived.
module tb_multicycle_control_unit;
  import multicycle_control_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready;
  logic        alu_zero_lt;
  logic        mem_req, mem_is_fetch, mem_read_signed, ir_write, pc_write;
  logic [3:0]  mem_we;
  logic [1:0]  mem_read_size, pc_src, alu_src_a, alu_src_b, wb_sel;
  logic [2:0]  imm_sel, branch_type;
  alu_op_t     alu_op;
  logic        reg_write, illegal, bus_error, instret;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] I_ADD      = 32'h002081B3;
  localparam logic [31:0] I_LW       = 32'h0000A283;
  localparam logic [31:0] I_SH       = 32'h00209223;
  localparam logic [31:0] I_BEQ      = 32'h00208463;
  localparam logic [31:0] I_JAL      = 32'h000000EF;
  localparam logic [31:0] I_SRAI     = 32'h4010D093;
  localparam logic [31:0] I_SRAI_BAD = 32'h8010D093;
  localparam logic [31:0] I_BADOP    = 32'h0000007F;

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .MEM_TIMEOUT  (16),
    .ENABLE_JUMPS (1'b1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .instr           (instr),
    .mem_ready       (mem_ready),
    .alu_zero_lt     (alu_zero_lt),
    .mem_req         (mem_req),
    .mem_is_fetch    (mem_is_fetch),
    .mem_we          (mem_we),
    .mem_read_size   (mem_read_size),
    .mem_read_signed (mem_read_signed),
    .ir_write        (ir_write),
    .pc_write        (pc_write),
    .pc_src          (pc_src),
    .alu_op          (alu_op),
    .alu_src_a       (alu_src_a),
    .alu_src_b       (alu_src_b),
    .imm_sel         (imm_sel),
    .branch_type     (branch_type),
    .reg_write       (reg_write),
    .wb_sel          (wb_sel),
    .illegal         (illegal),
    .bus_error       (bus_error),
    .instret         (instret)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle's sampling point, drive inputs, settle.
  task automatic tick(input logic ready, input logic zlt);
    @(negedge clk);
    rst         = 1'b0;
    mem_ready   = ready;
    alu_zero_lt = zlt;
    #1;
  endtask

  // Hold reset for two edges and check the reset outputs; rst drops on next tick.
  task automatic do_reset();
    rst       = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_illegal", 32'(illegal), 0);
    check("rst_bus_error", 32'(bus_error), 0);
    check("rst_strobes", 32'({ir_write, pc_write, reg_write, instret}), 0);
    check("rst_mem_we", 32'(mem_we), 0);
  endtask

  initial begin
    rst = 1'b1; instr = I_ADD; mem_ready = 1'b0; alu_zero_lt = 1'b0;
    do_reset();

    // ADD: F D E W
    tick(1, 0);
    check("add_f_req", 32'(mem_req), 1);
    check("add_f_fetch", 32'(mem_is_fetch), 1);
    check("add_f_size", 32'(mem_read_size), 2);
    check("add_f_irw", 32'(ir_write), 1);
    check("add_f_pcw", 32'(pc_write), 0);
    tick(1, 0);
    check("add_d_quiet", 32'({mem_req, ir_write, pc_write, reg_write, instret}), 0);
    tick(1, 0);
    check("add_e_op", 32'(alu_op), 32'(ALU_ADD));
    check("add_e_srcs", 32'({alu_src_a, alu_src_b}), 0);
    check("add_e_regw", 32'({reg_write, pc_write}), 0);
    tick(1, 0);
    check("add_w_regw", 32'(reg_write), 1);
    check("add_w_instret", 32'(instret), 1);
    check("add_w_pc", 32'({pc_write, pc_src}), 32'b100);
    check("add_w_wbsel", 32'(wb_sel), 0);
    tick(1, 0);
    check("add_next_f", 32'({mem_req, mem_is_fetch, reg_write, instret}), 32'b1100);
    instr = I_LW;

    // LW with three wait states in MEM
    tick(1, 0);
    tick(1, 0);
    check("lw_e_srcb", 32'(alu_src_b), 1);
    check("lw_e_req", 32'(mem_req), 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0);
      check("lw_m_wait_req", 32'({mem_req, mem_is_fetch}), 32'b10);
      check("lw_m_wait_size", 32'(mem_read_size), 2);
      check("lw_m_wait_we", 32'({mem_we, reg_write}), 0);
    end
    tick(1, 0);
    check("lw_m_ready", 32'({mem_req, pc_write, instret, reg_write}), 32'b1000);
    tick(1, 0);
    check("lw_w", 32'({reg_write, instret, pc_write, wb_sel}), 32'b11101);
    tick(1, 0);
    check("lw_next_f", 32'({mem_req, mem_is_fetch}), 32'b11);
    instr = I_SH;

    // SH
    tick(1, 0);
    tick(1, 0);
    check("sh_e", 32'({mem_we, imm_sel, mem_req}), 32'b0000_001_0);
    tick(1, 0);
    check("sh_m_we", 32'(mem_we), 32'b0011);
    check("sh_m", 32'({mem_req, mem_is_fetch, pc_write, pc_src, instret, reg_write}),
          32'b1_0_1_00_1_0);
    tick(1, 0);
    check("sh_next_f", 32'({mem_we, mem_req, mem_is_fetch}), 32'b0000_1_1);
    instr = I_BEQ;

    // BEQ taken then not taken
    tick(1, 1);
    tick(1, 1);
    check("beq_t_op", 32'(alu_op), 32'(ALU_SUB));
    check("beq_t_ctl", 32'({alu_src_b, imm_sel, branch_type}), 32'b00_010_000);
    check("beq_t_pc", 32'({pc_write, pc_src, instret, reg_write}), 32'b1_01_1_0);
    tick(1, 0);
    check("beq_t_next_f", 32'(mem_req), 1);
    tick(1, 0);
    tick(1, 0);
    check("beq_nt_pc", 32'({pc_write, pc_src, instret, reg_write}), 32'b1_00_1_0);
    tick(1, 0);
    check("beq_nt_next_f", 32'(mem_req), 1);
    instr = I_JAL;

    // JAL
    tick(1, 0);
    tick(1, 0);
    check("jal_e", 32'({pc_write, pc_src, imm_sel, reg_write}), 32'b1_01_100_0);
    tick(1, 0);
    check("jal_w", 32'({reg_write, instret, pc_write, wb_sel}), 32'b1_1_0_10);
    tick(1, 0);
    check("jal_next_f", 32'(mem_req), 1);
    instr = I_SRAI;

    // Legal SRAI
    tick(1, 0);
    tick(1, 0);
    check("srai_e_op", 32'(alu_op), 32'(ALU_SRA));
    check("srai_e_srcb", 32'(alu_src_b), 1);
    tick(1, 0);
    check("srai_w", 32'(reg_write), 1);
    tick(1, 0);
    instr = I_BADOP;

    // Unknown opcode traps
    tick(1, 0);
    check("bad_d_req", 32'(mem_req), 0);
    for (int i = 0; i < 4; i++) begin
      tick(1, 0);
      check("bad_trap_flag", 32'(illegal), 1);
      check("bad_trap_quiet", 32'({mem_req, pc_write, reg_write, instret}), 0);
    end
    instr = I_SRAI_BAD;
    do_reset();
    tick(1, 0);
    check("post_rst_f", 32'({mem_req, illegal}), 32'b10);
    tick(1, 0);
    tick(1, 0);
    check("srai_bad_trap", 32'({illegal, mem_req}), 32'b10);

    // Fetch timeout with no ready
    instr = I_ADD;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick(0, 0);
      check("to_wait", 32'({mem_req, bus_error}), 32'b10);
    end
    tick(0, 0);
    check("to_trap", 32'({mem_req, bus_error}), 32'b01);
    tick(1, 0);
    check("to_sticky", 32'({mem_req, bus_error, ir_write}), 32'b010);

    // Ready arrives in the last allowed cycle
    do_reset();
    for (int i = 0; i < 15; i++) tick(0, 0);
    tick(1, 0);
    check("late_ready_f", 32'({mem_req, ir_write, bus_error}), 32'b110);
    tick(1, 0);
    check("late_ready_d", 32'({mem_req, bus_error}), 0);
    tick(1, 0);
    tick(1, 0);
    check("late_ready_w", 32'({reg_write, bus_error}), 32'b10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
